// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - instruction-fetch request handshake between the PC unit and instruction memory
//
// Purpose : groups the fetch request/accept signals into one bundle.
// Signals :
//    fetch_valid  1   fetch request (driven by the PC unit)
//    fetch_addr   32  fetch address (driven by the PC unit, always equals pc)
//    fetch_ready  1   instruction memory accepts the request this cycle
// Modports:
//    master - PC unit side (drives fetch_valid/fetch_addr, samples fetch_ready)
//    slave  - instruction memory side

interface fetch_pc_unit_if;
   logic        fetch_valid;
   logic [31:0] fetch_addr;
   logic        fetch_ready;

   modport master (
      output fetch_valid,
      output fetch_addr,
      input  fetch_ready
   );

   modport slave (
      input  fetch_valid,
      input  fetch_addr,
      output fetch_ready
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter and instruction-fetch front end with EX-stage redirect
//
// Purpose : holds the PC, issues fetch requests, loads the IF/ID register,
//           redirects to the EX-stage target on a taken branch/jump, squashes
//           the wrong-path fetch and counts redirects.
// Optional: define ALIGN_CHECK_EN to force redirect targets to word alignment
//           and raise the sticky addr_fault flag on a misaligned target.
// Parameters:
//    RESET_PC        PC value loaded on reset
//    PC_INC          sequential PC increment in bytes
// Ports:
//    clk             system clock, rising edge
//    rst_n           synchronous active-low reset
//    stall           hazard-unit stall; freezes PC and IF/ID
//    branch_taken    EX-stage redirect strobe
//    BranchAddress   EX-stage computed target
//    fbus            fetch handshake (master side): fetch_valid/fetch_addr/fetch_ready
//    ifid_pc         PC of the instruction held in IF/ID
//    ifid_valid      IF/ID holds a valid instruction
//    flush           one-cycle squash pulse to IF/ID and ID/EX
//    redirect_count  saturating count of accepted redirects
//    addr_fault      sticky misaligned-target flag (0 unless ALIGN_CHECK_EN)

module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [31:0]            BranchAddress,
   fetch_pc_unit_if.master        fbus,
   output logic [31:0]            ifid_pc,
   output logic                   ifid_valid,
   output logic                   flush,
   output logic [15:0]            redirect_count,
   output logic                   addr_fault
);

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_FETCH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        fetch_valid_q;
   logic [31:0] redirect_target;
   logic        target_misaligned;

   // Target actually loaded into pc on a redirect.
`ifdef ALIGN_CHECK_EN
   assign redirect_target   = {BranchAddress[31:2], 2'b00};
   assign target_misaligned = (BranchAddress[1:0] != 2'b00);
`else
   assign redirect_target   = BranchAddress;
   assign target_misaligned = 1'b0;
`endif

   assign fbus.fetch_addr  = pc;
   assign fbus.fetch_valid = fetch_valid_q;

   // fetch_valid is registered: it is 1 exactly when the next state is FETCH,
   // so it is computed alongside every state transition below.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ST_BOOT;
         pc             <= RESET_PC;
         fetch_valid_q  <= 1'b0;
         ifid_pc        <= 32'h0000_0000;
         ifid_valid     <= 1'b0;
         flush          <= 1'b0;
         redirect_count <= 16'h0000;
      end else begin
         flush <= 1'b0;
         if (branch_taken) begin
            // Redirect beats stall and fetch_ready in every non-reset state.
            state         <= ST_REDIRECT;
            pc            <= redirect_target;
            fetch_valid_q <= 1'b0;
            ifid_valid    <= 1'b0;
            flush         <= 1'b1;
            if (redirect_count != 16'hFFFF)
               redirect_count <= redirect_count + 16'd1;
         end else begin
            case (state)
               ST_BOOT: begin
                  state         <= ST_FETCH;
                  fetch_valid_q <= 1'b1;
               end
               ST_FETCH: begin
                  fetch_valid_q <= 1'b1;
                  if (stall) begin
                     // A handshake completing under stall is dropped; the
                     // same pc is requested again once the stall clears.
                  end else if (fbus.fetch_ready) begin
                     ifid_pc    <= pc;
                     ifid_valid <= 1'b1;
                     pc         <= pc + PC_INC;
                  end else begin
                     ifid_valid <= 1'b0;
                  end
               end
               ST_REDIRECT: begin
                  // One squash bubble after the redirect, then fetch resumes.
                  state         <= ST_FETCH;
                  fetch_valid_q <= 1'b1;
               end
               default: begin
                  state         <= ST_BOOT;
                  fetch_valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef ALIGN_CHECK_EN
   // Sticky until reset.
   always_ff @(posedge clk) begin
      if (!rst_n)
         addr_fault <= 1'b0;
      else if (branch_taken && target_misaligned)
         addr_fault <= 1'b1;
   end
`else
   assign addr_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit

module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [31:0] BranchAddress;
   logic [31:0] ifid_pc;
   logic        ifid_valid;
   logic        flush;
   logic [15:0] redirect_count;
   logic        addr_fault;

   int vectors = 0;
   int miscompares = 0;

   fetch_pc_unit_if bus ();

   fetch_pc_unit #(
      .RESET_PC (32'h0000_0000),
      .PC_INC   (32'd4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .BranchAddress  (BranchAddress),
      .fbus           (bus.master),
      .ifid_pc        (ifid_pc),
      .ifid_valid     (ifid_valid),
      .flush          (flush),
      .redirect_count (redirect_count),
      .addr_fault     (addr_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full observable state after a step.
   task automatic chk_all(input string tag, input logic fv, input logic [31:0] addr,
                          input logic [31:0] ipc, input logic iv, input logic fl,
                          input logic [15:0] cnt);
      chk({tag, ".fetch_valid"},    32'(bus.fetch_valid), 32'(fv));
      chk({tag, ".fetch_addr"},     bus.fetch_addr,       addr);
      chk({tag, ".ifid_pc"},        ifid_pc,              ipc);
      chk({tag, ".ifid_valid"},     32'(ifid_valid),      32'(iv));
      chk({tag, ".flush"},          32'(flush),           32'(fl));
      chk({tag, ".redirect_count"}, 32'(redirect_count),  32'(cnt));
   endtask

   logic        exp_fault;
   logic [31:0] exp_mis_pc;

   initial begin
`ifdef ALIGN_CHECK_EN
      exp_fault  = 1'b1;
      exp_mis_pc = 32'h0000_0100;
`else
      exp_fault  = 1'b0;
      exp_mis_pc = 32'h0000_0102;
`endif
      rst_n         = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      BranchAddress = 32'h0;
      bus.fetch_ready = 1'b1;

      // Reset
      step();
      step();
      chk_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
      chk("reset.addr_fault", 32'(addr_fault), 32'h0);

      // BOOT -> FETCH, then sequential fetch with fetch_ready held high
      rst_n = 1'b1;
      step();
      chk_all("boot_exit", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
      step(); chk_all("seq0", 1'b1, 32'h4,  32'h0, 1'b1, 1'b0, 16'd0);
      step(); chk_all("seq1", 1'b1, 32'h8,  32'h4, 1'b1, 1'b0, 16'd0);
      step(); chk_all("seq2", 1'b1, 32'hC,  32'h8, 1'b1, 1'b0, 16'd0);
      step(); chk_all("seq3", 1'b1, 32'h10, 32'hC, 1'b1, 1'b0, 16'd0);

      // fetch_ready low for 3 cycles at pc=0x10
      bus.fetch_ready = 1'b0;
      step(); chk_all("bubble0", 1'b1, 32'h10, 32'hC, 1'b0, 1'b0, 16'd0);
      step(); chk_all("bubble1", 1'b1, 32'h10, 32'hC, 1'b0, 1'b0, 16'd0);
      step(); chk_all("bubble2", 1'b1, 32'h10, 32'hC, 1'b0, 1'b0, 16'd0);
      bus.fetch_ready = 1'b1;
      step(); chk_all("unbubble", 1'b1, 32'h14, 32'h10, 1'b1, 1'b0, 16'd0);

      // Stall for 2 cycles with ready high: handshake ignored, all frozen
      stall = 1'b1;
      step(); chk_all("stall0", 1'b1, 32'h14, 32'h10, 1'b1, 1'b0, 16'd0);
      step(); chk_all("stall1", 1'b1, 32'h14, 32'h10, 1'b1, 1'b0, 16'd0);
      stall = 1'b0;
      step(); chk_all("resume0", 1'b1, 32'h18, 32'h14, 1'b1, 1'b0, 16'd0);
      step(); chk_all("resume1", 1'b1, 32'h1C, 32'h18, 1'b1, 1'b0, 16'd0);

      // Redirect while stalled: redirect wins
      stall = 1'b1; branch_taken = 1'b1; BranchAddress = 32'h100;
      step(); chk_all("br_stall", 1'b0, 32'h100, 32'h18, 1'b0, 1'b1, 16'd1);
      stall = 1'b0; branch_taken = 1'b0;
      step(); chk_all("br_bubble", 1'b1, 32'h100, 32'h18, 1'b0, 1'b0, 16'd1);
      step(); chk_all("br_first", 1'b1, 32'h104, 32'h100, 1'b1, 1'b0, 16'd1);

      // Back-to-back redirects 0x200 then 0x300
      branch_taken = 1'b1; BranchAddress = 32'h200;
      step(); chk_all("b2b_0", 1'b0, 32'h200, 32'h100, 1'b0, 1'b1, 16'd2);
      BranchAddress = 32'h300;
      step(); chk_all("b2b_1", 1'b0, 32'h300, 32'h100, 1'b0, 1'b1, 16'd3);
      branch_taken = 1'b0;
      step(); chk_all("b2b_bub", 1'b1, 32'h300, 32'h100, 1'b0, 1'b0, 16'd3);
      step(); chk_all("b2b_first", 1'b1, 32'h304, 32'h300, 1'b1, 1'b0, 16'd3);

      // PC wrap at 0xFFFFFFFC
      branch_taken = 1'b1; BranchAddress = 32'hFFFF_FFFC;
      step(); chk_all("wrap_br", 1'b0, 32'hFFFF_FFFC, 32'h300, 1'b0, 1'b1, 16'd4);
      branch_taken = 1'b0;
      step();
      step(); chk_all("wrap", 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 16'd4);

      // Misaligned target
      branch_taken = 1'b1; BranchAddress = 32'h102;
      step(); chk_all("mis_br", 1'b0, exp_mis_pc, 32'hFFFF_FFFC, 1'b0, 1'b1, 16'd5);
      chk("mis_br.addr_fault", 32'(addr_fault), 32'(exp_fault));
      branch_taken = 1'b0;
      step();
      step(); chk_all("mis_fetch", 1'b1, exp_mis_pc + 32'h4, exp_mis_pc, 1'b1, 1'b0, 16'd5);
      chk("mis_sticky.addr_fault", 32'(addr_fault), 32'(exp_fault));

      // Reset overrides a simultaneous branch_taken
      rst_n = 1'b0; branch_taken = 1'b1; BranchAddress = 32'h500;
      step(); chk_all("rst_br", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
      chk("rst_br.addr_fault", 32'(addr_fault), 32'h0);

      // Redirect straight out of BOOT
      rst_n = 1'b1; BranchAddress = 32'h40;
      step(); chk_all("boot_br", 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 16'd1);
      branch_taken = 1'b0;
      step(); chk_all("boot_br_bub", 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 16'd1);
      step(); chk_all("boot_br_first", 1'b1, 32'h44, 32'h40, 1'b1, 1'b0, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
